// File: rtl/mf_disp_scan_gen_pkg.sv
// Shared defaults (640x480@60, 8x replication) and swap FSM encoding for the
// display scan-out controller.
package mf_disp_scan_gen_pkg;

    localparam int DEF_H_ACT    = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACT    = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_SCALE_SH = 3;
    localparam int DEF_IMG_W    = 80;
    localparam int DEF_RD_LAT   = 3;

    typedef enum logic {
        SW_IDLE = 1'b0,
        SW_PEND = 1'b1
    } swap_state_e;

endpackage

// File: rtl/mf_disp_delay_pipe.sv
// Fixed-depth shift register used to align timing flags with read data.
module mf_disp_delay_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mf_disp_scan_gen.sv
// Pixel-clock scan-out: H/V timing, replicated frame-buffer read addressing,
// sync/blank realignment with returned RGB, and vblank-aligned buffer swap.
module mf_disp_scan_gen
    import mf_disp_scan_gen_pkg::*;
#(
    parameter int   H_ACT    = DEF_H_ACT,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACT    = DEF_V_ACT,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   SCALE_SH = DEF_SCALE_SH,
    parameter int   IMG_W    = DEF_IMG_W,
    parameter int   RD_LAT   = DEF_RD_LAT
) (
    input  logic        pix_clk,
    input  logic        reset,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        pix_fb_active_sel,
    output logic        pix_rd_vld,
    output logic [15:0] pix_rd_addr,
    input  logic [5:0]  pix_rd_rdata,
    input  logic [5:0]  pix_rd_gdata,
    input  logic [5:0]  pix_rd_bdata,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [5:0]  vga_r,
    output logic [5:0]  vga_g,
    output logic [5:0]  vga_b
);

    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACT);
    localparam logic [HW-1:0] H_ALAST_C = HW'(H_ACT - 1);
    localparam logic [HW-1:0] H_SS_C    = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0] H_SE_C    = HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C  = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACT);
    localparam logic [VW-1:0] V_ALAST_C = VW'(V_ACT - 1);
    localparam logic [VW-1:0] V_SS_C    = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0] V_SE_C    = VW'(V_ACT + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C  = VW'(V_TOT - 1);
    localparam logic [13:0]   IMG_W_C   = 14'(IMG_W);

    // ---------------- timing counters ----------------
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_end, v_end, act, hs_on, vs_on;

    assign h_end = (h_q == H_LAST_C);
    assign v_end = (v_q == V_LAST_C);
    assign act   = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign hs_on = (h_q >= H_SS_C) && (h_q < H_SE_C);
    assign vs_on = (v_q >= V_SS_C) && (v_q < V_SE_C);

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_end) begin
            h_d = '0;
            v_d = v_end ? '0 : v_q + 1'b1;
        end
    end

    // ---------------- incremental address generator ----------------
    logic [13:0]         idx_q, idx_d, base_q, base_d;
    logic [SCALE_SH-1:0] hrep_q, hrep_d, vrep_q, vrep_d;

    always_comb begin
        idx_d  = idx_q;
        base_d = base_q;
        hrep_d = hrep_q;
        vrep_d = vrep_q;
        if (act) begin
            hrep_d = hrep_q + 1'b1;
            if (hrep_q == '1) idx_d = idx_q + 14'd1;
            // End of an active line: rewind to this source line or step to the next one.
            if (h_q == H_ALAST_C) begin
                hrep_d = '0;
                vrep_d = vrep_q + 1'b1;
                if (vrep_q == '1) begin
                    base_d = base_q + IMG_W_C;
                    idx_d  = base_q + IMG_W_C;
                end else begin
                    idx_d  = base_q;
                end
            end
        end
        if (h_end && v_end) begin
            idx_d  = '0;
            base_d = '0;
            hrep_d = '0;
            vrep_d = '0;
        end
    end

    // ---------------- swap FSM ----------------
    swap_state_e st_q, st_d;
    logic        swap_pt, take;

    assign swap_pt = h_end && (v_q == V_ALAST_C);

    always_comb begin
        st_d = st_q;
        take = 1'b0;
        if (swap_pt && (st_q == SW_PEND || swap_req)) begin
            take = 1'b1;
            st_d = SW_IDLE;
        end else if (swap_req) begin
            st_d = SW_PEND;
        end
    end

    // ---------------- flag alignment ----------------
    // Sync is carried as an "asserted" flag so a cleared pipe means idle sync.
    logic [2:0] flags_t;

    mf_disp_delay_pipe #(
        .WIDTH (3),
        .DEPTH (1 + RD_LAT)
    ) u_flag_pipe (
        .clk_i   (pix_clk),
        .reset_i (reset),
        .d_i     ({act, hs_on, vs_on}),
        .q_o     (flags_t)
    );

    logic        rd_vld_q, de_q, hs_q, vs_q, sel_q, ack_q;
    logic [15:0] rd_addr_q;
    logic [5:0]  r_q, g_q, b_q;

    always_ff @(posedge pix_clk) begin
        if (reset) begin
            h_q       <= '0;
            v_q       <= '0;
            idx_q     <= '0;
            base_q    <= '0;
            hrep_q    <= '0;
            vrep_q    <= '0;
            st_q      <= SW_IDLE;
            sel_q     <= 1'b0;
            ack_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            de_q      <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            hrep_q    <= hrep_d;
            vrep_q    <= vrep_d;
            st_q      <= st_d;
            sel_q     <= sel_q ^ take;
            ack_q     <= take;
            rd_vld_q  <= act;
            if (act) rd_addr_q <= {idx_q, 2'b00};
            de_q      <= flags_t[2];
            hs_q      <= flags_t[1] ? HS_POL : ~HS_POL;
            vs_q      <= flags_t[0] ? VS_POL : ~VS_POL;
            r_q       <= flags_t[2] ? pix_rd_rdata : '0;
            g_q       <= flags_t[2] ? pix_rd_gdata : '0;
            b_q       <= flags_t[2] ? pix_rd_bdata : '0;
        end
    end

    assign swap_ack          = ack_q;
    assign pix_fb_active_sel = sel_q;
    assign pix_rd_vld        = rd_vld_q;
    assign pix_rd_addr       = rd_addr_q;
    assign vga_de            = de_q;
    assign vga_hs            = hs_q;
    assign vga_vs            = vs_q;
    assign vga_r             = r_q;
    assign vga_g             = g_q;
    assign vga_b             = b_q;

endmodule

// File: tb/tb_mf_disp_scan_gen.sv
// Scoreboard bench for mf_disp_scan_gen on a reduced raster (48x23, 4x replication).
module tb_mf_disp_scan_gen;

    localparam int HA = 32, HF = 4, HS = 6, HB = 6, HT = HA + HF + HS + HB;
    localparam int VA = 16, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int SH = 2, IW = 8, LAT = 3;

    logic        pix_clk = 1'b0, reset = 1'b1, swap_req = 1'b0;
    logic        swap_ack, pix_fb_active_sel, pix_rd_vld;
    logic [15:0] pix_rd_addr;
    logic [5:0]  pix_rd_rdata, pix_rd_gdata, pix_rd_bdata;
    logic        vga_hs, vga_vs, vga_de;
    logic [5:0]  vga_r, vga_g, vga_b;

    mf_disp_scan_gen #(
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .SCALE_SH(SH), .IMG_W(IW), .RD_LAT(LAT)
    ) dut (
        .pix_clk(pix_clk), .reset(reset), .swap_req(swap_req), .swap_ack(swap_ack),
        .pix_fb_active_sel(pix_fb_active_sel), .pix_rd_vld(pix_rd_vld),
        .pix_rd_addr(pix_rd_addr), .pix_rd_rdata(pix_rd_rdata),
        .pix_rd_gdata(pix_rd_gdata), .pix_rd_bdata(pix_rd_bdata),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 pix_clk = ~pix_clk;

    // Frame buffer: 3-cycle read latency, data derived from the address.
    logic [15:0] a1 = '0, a2 = '0, a3 = '0;
    always @(posedge pix_clk) begin
        a1 <= pix_rd_addr;
        a2 <= a1;
        a3 <= a2;
    end
    assign pix_rd_rdata = a3[7:2];
    assign pix_rd_gdata = ~a3[7:2];
    assign pix_rd_bdata = a3[13:8];

    typedef struct packed { logic vld; logic [15:0] addr; } rd_t;
    typedef struct packed { logic de; logic hs; logic vs; logic [17:0] rgb; } vo_t;

    rd_t rdq[$];
    vo_t vq[$];
    int n_chk = 0, n_err = 0;
    int mh, mv, mf, cyc, ack_cnt, idx;
    logic mpend, esel, eack, act, hs_on, vs_on, req, take;
    logic [15:0] eaddr;
    logic [13:0] ia;
    rd_t er;
    vo_t ev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d frame=%0d)", tag, got, exp, mh, mv, mf);
        end
    endtask

    task automatic model_init();
        mh = 0; mv = 0; mpend = 1'b0; esel = 1'b0; eack = 1'b0; eaddr = '0;
        rdq.delete();
        vq.delete();
        rdq.push_back('{vld: 1'b0, addr: 16'h0});
        repeat (LAT + 2) vq.push_back('{de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 18'h0});
    endtask

    task automatic do_reset(input int n, input string tag);
        reset = 1'b1;
        swap_req = 1'b0;
        repeat (n) @(posedge pix_clk);
        #1;
        chk({tag, "_hs"}, vga_hs, 1);
        chk({tag, "_vs"}, vga_vs, 1);
        chk({tag, "_de"}, vga_de, 0);
        chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
        chk({tag, "_rd_vld"}, pix_rd_vld, 0);
        chk({tag, "_rd_addr"}, pix_rd_addr, 0);
        chk({tag, "_sel"}, pix_fb_active_sel, 0);
        chk({tag, "_ack"}, swap_ack, 0);
        reset = 1'b0;
        model_init();
    endtask

    // Swap requests: single, double-merged, in-swap-cycle, just-after-swap, dropped by reset.
    function automatic logic sched(input int f, input int h, input int v);
        case (f)
            0:       return (v == 5 && h == 10);
            1:       return (v == 3 && h == 0) || (v == 8 && h == 20);
            2:       return (v == VA - 1 && h == HT - 1) || (v == VA && h == 0);
            4:       return (v == 2 && h == 0);
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        mh = 0; mv = 0; mf = 0; cyc = 0; ack_cnt = 0;
        do_reset(5, "rst");
        while (mf < 6 && cyc < 20000) begin
            er = rdq.pop_front();
            chk("rd_vld", pix_rd_vld, er.vld);
            chk("rd_addr", pix_rd_addr, er.addr);
            ev = vq.pop_front();
            chk("vga_de", vga_de, ev.de);
            chk("vga_hs", vga_hs, ev.hs);
            chk("vga_vs", vga_vs, ev.vs);
            chk("vga_rgb", {vga_r, vga_g, vga_b}, ev.rgb);
            chk("sel", pix_fb_active_sel, esel);
            chk("ack", swap_ack, eack);
            if (swap_ack) ack_cnt++;

            if (mf == 4 && mv == 10 && mh == 30) begin
                do_reset(1, "mid");
                mf = 5;
                continue;
            end

            act   = (mh < HA) && (mv < VA);
            idx   = (mv >> SH) * IW + (mh >> SH);
            ia    = 14'(idx);
            if (act) eaddr = {ia, 2'b00};
            rdq.push_back('{vld: act, addr: eaddr});
            hs_on = (mh >= HA + HF) && (mh < HA + HF + HS);
            vs_on = (mv >= VA + VF) && (mv < VA + VF + VS);
            ev.de  = act;
            ev.hs  = ~hs_on;
            ev.vs  = ~vs_on;
            ev.rgb = act ? {ia[5:0], ~ia[5:0], ia[11:6]} : 18'h0;
            vq.push_back(ev);

            req      = sched(mf, mh, mv);
            swap_req = req;
            take     = (mh == HT - 1 && mv == VA - 1) && (mpend || req);
            if (take) begin
                esel  = ~esel;
                mpend = 1'b0;
            end else if (req) begin
                mpend = 1'b1;
            end
            eack = take;

            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) begin
                    mv = 0;
                    mf++;
                end
            end
            cyc++;
            @(posedge pix_clk);
            #1;
        end
        swap_req = 1'b0;
        chk("frames_done", mf, 6);
        chk("ack_cnt", ack_cnt, 4);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
